// File: rtl/vga_sync_640_480_pkg.sv
// Shared 640x480@60 timing constants and the registered position-decode record
// used by the VGA sync generator.
package vga_sync_640_480_pkg;

  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  localparam int unsigned POS_W  = 10;
  localparam int unsigned VIDX_W = 9;

  typedef logic [POS_W-1:0] pos_t;

  typedef struct packed {
    logic              haddr_en;
    logic              vaddr_en;
    logic [POS_W-1:0]  hidx;
    logic [VIDX_W-1:0] vidx;
    logic              hsync_n;
    logic              vsync_n;
  } pos_dec_t;

  // Half-open window test [lo, hi) on a counter value.
  function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_sync_640_480_counter_n_en.sv
// Enabled modulo counter: counts 0..MAX while en=1, exposing the value it will
// take at the next edge and a one-cycle wrap strobe.
module counter_n_en #(
  parameter int unsigned    W       = 10,
  parameter logic [W-1:0]   MAX     = '1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] cnt_nxt,
  output logic         wrap
);

  logic [W-1:0] cnt;
  logic         at_max;

  assign at_max = (cnt == MAX);
  assign wrap   = en & at_max;

  always_comb begin
    cnt_nxt = cnt;
    if (en) begin
      cnt_nxt = at_max ? '0 : cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= RST_VAL;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_sync_640_480.sv
// VGA 640x480@60 pixel-timing generator: pixel-rate tick, h/v position counters,
// registered active-area enables, pixel indices and negative-polarity syncs.
module vga_sync_640_480
  import vga_sync_640_480_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_en,
  output logic       o_px_clk,
  output logic       o_haddr_en,
  output logic       o_vaddr_en,
  output logic [9:0] o_hidx,
  output logic [8:0] o_vidx,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam pos_t H_MAX    = POS_W'(H_TOTAL - 1);
  localparam pos_t V_MAX    = POS_W'(V_TOTAL - 1);
  localparam pos_t H_ACT    = POS_W'(H_ACTIVE);
  localparam pos_t V_ACT    = POS_W'(V_ACTIVE);
  localparam pos_t HS_START = POS_W'(H_ACTIVE + H_FP);
  localparam pos_t HS_END   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam pos_t VS_START = POS_W'(V_ACTIVE + V_FP);
  localparam pos_t VS_END   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  // Decode of the reset position (H_TOTAL-1, V_TOTAL-1): blanked, syncs idle.
  localparam pos_dec_t DEC_RST = '{haddr_en: 1'b0, vaddr_en: 1'b0, hidx: '0,
                                   vidx: '0, hsync_n: 1'b1, vsync_n: 1'b1};

  logic [DIV_W-1:0] div_nxt;
  logic             tick;
  logic             h_wrap;
  logic             v_wrap_unused;
  pos_t             hcnt_nxt;
  pos_t             vcnt_nxt;
  logic             primed;
  logic             primed_nxt;
  logic             px_nxt;
  logic             origin_nxt;
  pos_dec_t         dec_nxt;
  pos_dec_t         dec_q;

  counter_n_en #(.W(DIV_W), .MAX(DIV_MAX), .RST_VAL('0)) u_div (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .en      (i_en),
    .cnt_nxt (div_nxt),
    .wrap    (tick)
  );

  counter_n_en #(.W(POS_W), .MAX(H_MAX), .RST_VAL(H_MAX)) u_hcnt (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .en      (tick),
    .cnt_nxt (hcnt_nxt),
    .wrap    (h_wrap)
  );

  // Frame origin is decoded from the next counts, so the v wrap strobe is spare.
  counter_n_en #(.W(POS_W), .MAX(V_MAX), .RST_VAL(V_MAX)) u_vcnt (
    .clk     (clk),
    .rst_n   (i_rst_n),
    .en      (h_wrap),
    .cnt_nxt (vcnt_nxt),
    .wrap    (v_wrap_unused)
  );

  always_comb begin
    dec_nxt          = DEC_RST;
    dec_nxt.haddr_en = (hcnt_nxt < H_ACT);
    dec_nxt.vaddr_en = (vcnt_nxt < V_ACT);
    dec_nxt.hidx     = dec_nxt.haddr_en ? hcnt_nxt : '0;
    dec_nxt.vidx     = dec_nxt.vaddr_en ? vcnt_nxt[VIDX_W-1:0] : '0;
    dec_nxt.hsync_n  = ~in_window(hcnt_nxt, HS_START, HS_END);
    dec_nxt.vsync_n  = ~in_window(vcnt_nxt, VS_START, VS_END);
  end

  // The reset position is never presented as a pixel: the pixel strobe stays
  // quiet until the first tick has moved the counters to (0,0).
  assign primed_nxt = primed | tick;
  assign px_nxt     = i_en & primed_nxt & (div_nxt == DIV_MAX);
  assign origin_nxt = (hcnt_nxt == '0) && (vcnt_nxt == '0);

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dec_q         <= DEC_RST;
      primed        <= 1'b0;
      o_px_clk      <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      dec_q         <= dec_nxt;
      primed        <= primed_nxt;
      o_px_clk      <= px_nxt;
      o_frame_start <= px_nxt & origin_nxt;
    end
  end

  assign o_haddr_en = dec_q.haddr_en;
  assign o_vaddr_en = dec_q.vaddr_en;
  assign o_hidx     = dec_q.hidx;
  assign o_vidx     = dec_q.vidx;
  assign o_hsync_n  = dec_q.hsync_n;
  assign o_vsync_n  = dec_q.vsync_n;

endmodule

// File: tb/tb_vga_sync_640_480.sv
// Bench for vga_sync_640_480: full-size instances at CLK_DIV 2 and 1 plus a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_sync_640_480;

  typedef struct packed {
    logic       px;
    logic       fs;
    logic       haddr;
    logic       vaddr;
    logic [9:0] hidx;
    logic [8:0] vidx;
    logic       hs;
    logic       vs;
  } out_t;

  typedef struct {
    int   run;
    logic en;
    out_t exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic i_en;

  always #5 clk = ~clk;

  logic       px2, fs2, ha2, va2, hs2, vs2;
  logic [9:0] hidx2;
  logic [8:0] vidx2;
  logic       px1, fs1, ha1, va1, hs1, vs1;
  logic [9:0] hidx1;
  logic [8:0] vidx1;
  logic       pxs, fss, has, vas, hss, vss;
  logic [9:0] hidxs;
  logic [8:0] vidxs;
  out_t       act2, act1, acts;

  vga_sync_640_480 #(.CLK_DIV(2)) u_dut2 (
    .clk(clk), .i_rst_n(rst_n), .i_en(i_en), .o_px_clk(px2), .o_haddr_en(ha2),
    .o_vaddr_en(va2), .o_hidx(hidx2), .o_vidx(vidx2), .o_hsync_n(hs2),
    .o_vsync_n(vs2), .o_frame_start(fs2)
  );

  vga_sync_640_480 #(.CLK_DIV(1)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_en(i_en), .o_px_clk(px1), .o_haddr_en(ha1),
    .o_vaddr_en(va1), .o_hidx(hidx1), .o_vidx(vidx1), .o_hsync_n(hs1),
    .o_vsync_n(vs1), .o_frame_start(fs1)
  );

  vga_sync_640_480 #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_dut_s (
    .clk(clk), .i_rst_n(rst_n), .i_en(i_en), .o_px_clk(pxs), .o_haddr_en(has),
    .o_vaddr_en(vas), .o_hidx(hidxs), .o_vidx(vidxs), .o_hsync_n(hss),
    .o_vsync_n(vss), .o_frame_start(fss)
  );

  assign act2 = {px2, fs2, ha2, va2, hidx2, vidx2, hs2, vs2};
  assign act1 = {px1, fs1, ha1, va1, hidx1, vidx1, hs1, vs1};
  assign acts = {pxs, fss, has, vas, hidxs, vidxs, hss, vss};

  // Reference state: number of enabled clock edges since reset, and whether
  // the most recent edge was enabled.
  int   n_en    = 0;
  logic last_en = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_en    <= 0;
      last_en <= 1'b0;
    end else begin
      if (i_en) n_en <= n_en + 1;
      last_en <= i_en;
    end
  end

  // Position is the raster index reached after n/cd pixel ticks, starting one
  // before (0,0); the strobe marks the last clock of each pixel period.
  function automatic out_t model(input int n, input logic le, input int cd,
                                 input int ha, input int hfp, input int hs, input int hbp,
                                 input int va, input int vfp, input int vs, input int vbp);
    int   ht, vt, p, pos, h, v;
    out_t o;
    ht      = ha + hfp + hs + hbp;
    vt      = va + vfp + vs + vbp;
    p       = n / cd;
    pos     = (p + ht * vt - 1) % (ht * vt);
    h       = pos % ht;
    v       = pos / ht;
    o.px    = le && (p >= 1) && ((n % cd) == cd - 1);
    o.fs    = o.px && (h == 0) && (v == 0);
    o.haddr = (h < ha);
    o.vaddr = (v < va);
    o.hidx  = o.haddr ? 10'(h) : 10'd0;
    o.vidx  = o.vaddr ? 9'(v) : 9'd0;
    o.hs    = !((h >= ha + hfp) && (h < ha + hfp + hs));
    o.vs    = !((v >= va + vfp) && (v < va + vfp + vs));
    return o;
  endfunction

  function automatic out_t mk(input bit px, input bit fs, input bit ha, input bit va,
                              input int hidx, input int vidx, input bit hs, input bit vs);
    out_t o;
    o.px    = px;
    o.fs    = fs;
    o.haddr = ha;
    o.vaddr = va;
    o.hidx  = 10'(hidx);
    o.vidx  = 9'(vidx);
    o.hs    = hs;
    o.vs    = vs;
    return o;
  endfunction

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input out_t act, input out_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s n=%0d: got %h expected %h", name, n_en, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all();
    check("model_div2", act2, model(n_en, last_en, 2, 640, 16, 96, 48, 480, 10, 2, 33));
    check("model_div1", act1, model(n_en, last_en, 1, 640, 16, 96, 48, 480, 10, 2, 33));
    check("model_small", acts, model(n_en, last_en, 3, 8, 2, 3, 2, 5, 2, 2, 3));
  endtask

  // Each call is entered at a falling edge; k rising edges see i_en=en_v.
  task automatic run(input int k, input logic en_v);
    i_en = en_v;
    repeat (k) begin
      @(negedge clk);
      check_all();
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_en  = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_all();
    end
    rst_n = 1'b1;
  endtask

  vec_t vecs[14];
  int   c_fs, c_vs, c_hs, c_px, c_ha;

  initial begin
    // Cumulative enabled-edge counts after each row: 3,4,5,1281,1283,1313,
    // 1315,1505,1507,1601,1603, pause x7, 1604,1605.
    vecs[0]  = '{3,    1'b1, mk(1, 1, 1, 1, 0,   0, 1, 1)};
    vecs[1]  = '{1,    1'b1, mk(0, 0, 1, 1, 1,   0, 1, 1)};
    vecs[2]  = '{1,    1'b1, mk(1, 0, 1, 1, 1,   0, 1, 1)};
    vecs[3]  = '{1276, 1'b1, mk(1, 0, 1, 1, 639, 0, 1, 1)};
    vecs[4]  = '{2,    1'b1, mk(1, 0, 0, 1, 0,   0, 1, 1)};
    vecs[5]  = '{30,   1'b1, mk(1, 0, 0, 1, 0,   0, 1, 1)};
    vecs[6]  = '{2,    1'b1, mk(1, 0, 0, 1, 0,   0, 0, 1)};
    vecs[7]  = '{190,  1'b1, mk(1, 0, 0, 1, 0,   0, 0, 1)};
    vecs[8]  = '{2,    1'b1, mk(1, 0, 0, 1, 0,   0, 1, 1)};
    vecs[9]  = '{94,   1'b1, mk(1, 0, 0, 1, 0,   0, 1, 1)};
    vecs[10] = '{2,    1'b1, mk(1, 0, 1, 1, 0,   1, 1, 1)};
    vecs[11] = '{7,    1'b0, mk(0, 0, 1, 1, 0,   1, 1, 1)};
    vecs[12] = '{1,    1'b1, mk(0, 0, 1, 1, 1,   1, 1, 1)};
    vecs[13] = '{1,    1'b1, mk(1, 0, 1, 1, 1,   1, 1, 1)};

    rst_n = 1'b0;
    i_en  = 1'b0;
    @(negedge clk);
    check("reset_div2", act2, mk(0, 0, 0, 0, 0, 0, 1, 1));
    check("reset_div1", act1, mk(0, 0, 0, 0, 0, 0, 1, 1));
    check("reset_small", acts, mk(0, 0, 0, 0, 0, 0, 1, 1));
    rst_n = 1'b1;

    // Line walk on the CLK_DIV=2 instance.
    for (int i = 0; i < 14; i++) begin
      run(vecs[i].run, vecs[i].en);
      check($sformatf("vec%0d", i), act2, vecs[i].exp);
    end

    // Pause at the last active pixel of the small raster: (7,4) at n=206.
    do_reset();
    run(206, 1'b1);
    check("small_pre_pause", acts, mk(1, 0, 1, 1, 7, 4, 1, 1));
    for (int i = 0; i < 7; i++) begin
      run(1, 1'b0);
      check($sformatf("small_pause%0d", i), acts, mk(0, 0, 1, 1, 7, 4, 1, 1));
    end
    run(3, 1'b1);
    check("small_resume", acts, mk(1, 0, 0, 1, 0, 4, 1, 1));

    // Two small frames: 2 frame starts, 2x30 vsync pixels, 24 lines x 3 hsync pixels.
    do_reset();
    i_en = 1'b1;
    c_fs = 0;
    c_vs = 0;
    c_hs = 0;
    for (int k = 0; k < 1080; k++) begin
      @(negedge clk);
      check_all();
      if (acts.fs) c_fs++;
      if (acts.px && !acts.vs) c_vs++;
      if (acts.px && !acts.hs) c_hs++;
    end
    check_int("small_frame_starts", c_fs, 2);
    check_int("small_vsync_px", c_vs, 60);
    check_int("small_hsync_px", c_hs, 72);

    // CLK_DIV=1: one line is 800 clocks with the strobe high throughout.
    do_reset();
    i_en = 1'b1;
    c_px = 0;
    c_ha = 0;
    c_hs = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      check_all();
      if (act1.px) c_px++;
      if (act1.px && act1.haddr) c_ha++;
      if (act1.px && !act1.hs) c_hs++;
    end
    check_int("div1_px_per_line", c_px, 800);
    check_int("div1_active_px", c_ha, 640);
    check_int("div1_hsync_px", c_hs, 96);

    // Asynchronous reset in the middle of hsync at (700,0).
    do_reset();
    run(1402, 1'b1);
    check("hsync_mid", act2, mk(0, 0, 0, 1, 0, 0, 0, 1));
    #2 rst_n = 1'b0;
    #1 check("async_reset", act2, mk(0, 0, 0, 0, 0, 0, 1, 1));
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    run(3, 1'b1);
    check("restart_origin", act2, mk(1, 1, 1, 1, 0, 0, 1, 1));

    // Random enable gaps and occasional mid-cycle resets.
    for (int it = 0; it < 300; it++) begin
      run($urandom_range(1, 30), 1'($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
